// File: rtl/arm_register_file_pkg.sv
// Shared constants for the register bank, the instruction decoder and the PC stage.
package arm_register_file_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int PC_IDX   = 15;
  localparam int LINK_REG = 14;

  // Architectural register aliases
  localparam int SP = 13;
  localparam int LR = 14;
  localparam int PC = 15;

  // Per-register next-state choice. Reset is handled separately in the flop.
  typedef enum logic [1:0] {
    WR_HOLD    = 2'd0,
    WR_GENERAL = 2'd1,
    WR_LINK    = 2'd2
  } wr_sel_e;

  // Write decode for one stored register. Full equality compare, so an
  // unknown address never selects a register. The general port wins over the
  // link port when both target the same register.
  function automatic wr_sel_e wr_decode(
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic              link_we,
    input logic              is_link,
    input logic [ADDR_W-1:0] idx
  );
    wr_sel_e sel;
    sel = WR_HOLD;
    if (link_we && is_link) sel = WR_LINK;
    if (we && (wa == idx))  sel = WR_GENERAL;
    return sel;
  endfunction

endpackage

// File: rtl/arm_register_file_read_mux.sv
// 16:1 read mux over R0-R14 with index 15 substituted by the live PC+8 value.
module regfile_read_mux #(
  parameter int DATA_W = arm_register_file_pkg::DATA_W
) (
  input  logic [arm_register_file_pkg::PC_IDX-1:0][DATA_W-1:0] regs_i,
  input  logic [DATA_W-1:0]                                    r15_i,
  input  logic [arm_register_file_pkg::ADDR_W-1:0]             addr_i,
  output logic [DATA_W-1:0]                                    data_o
);
  import arm_register_file_pkg::*;

  logic [NUM_REGS-1:0][DATA_W-1:0] all_regs;

  // Append R15 above the stored registers so every address is in range.
  always_comb begin
    all_regs = {r15_i, regs_i};
    data_o   = all_regs[addr_i];
  end

endmodule

// File: rtl/arm_register_file.sv
// ARM register bank: R0-R14 in flops, R15 supplied by the PC stage.
// Three operand read ports plus a debug port, one general write port and a
// dedicated link write port for BL.
module arm_register_file #(
  parameter int DATA_W   = arm_register_file_pkg::DATA_W,
  parameter int LINK_REG = arm_register_file_pkg::LINK_REG
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [arm_register_file_pkg::ADDR_W-1:0] RA1,
  input  logic [arm_register_file_pkg::ADDR_W-1:0] RA2,
  input  logic [arm_register_file_pkg::ADDR_W-1:0] RA3,
  input  logic [arm_register_file_pkg::ADDR_W-1:0] WA3,
  input  logic [DATA_W-1:0]                        WD3,
  input  logic                                     WE3,
  input  logic                                     LinkWE,
  input  logic [DATA_W-1:0]                        LinkData,
  input  logic [DATA_W-1:0]                        R15,
  input  logic [arm_register_file_pkg::ADDR_W-1:0] DbgSel,
  output logic [DATA_W-1:0]                        RD1,
  output logic [DATA_W-1:0]                        RD2,
  output logic [DATA_W-1:0]                        RD3,
  output logic [DATA_W-1:0]                        DbgOut
);
  import arm_register_file_pkg::*;

  localparam int NSTORE = PC_IDX;  // R0-R14 are stored; R15 is not

  logic [NSTORE-1:0][DATA_W-1:0] regs_q, regs_d;
  wr_sel_e                       wr_sel [NSTORE];

  // Per-register write decode; a write to index 15 matches nothing and is dropped.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NSTORE; i++) begin
      wr_sel[i] = wr_decode(WE3, WA3, LinkWE, (i == LINK_REG), ADDR_W'(i));
      case (wr_sel[i])
        WR_GENERAL: regs_d[i] = WD3;
        WR_LINK:    regs_d[i] = LinkData;
        default:    regs_d[i] = regs_q[i];
      endcase
    end
  end

  // Register bank; reset discards any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  // Read ports: combinational, no write-to-read bypass.
  regfile_read_mux #(.DATA_W(DATA_W)) u_rd1 (
    .regs_i(regs_q), .r15_i(R15), .addr_i(RA1), .data_o(RD1)
  );
  regfile_read_mux #(.DATA_W(DATA_W)) u_rd2 (
    .regs_i(regs_q), .r15_i(R15), .addr_i(RA2), .data_o(RD2)
  );
  regfile_read_mux #(.DATA_W(DATA_W)) u_rd3 (
    .regs_i(regs_q), .r15_i(R15), .addr_i(RA3), .data_o(RD3)
  );
  regfile_read_mux #(.DATA_W(DATA_W)) u_dbg (
    .regs_i(regs_q), .r15_i(R15), .addr_i(DbgSel), .data_o(DbgOut)
  );

endmodule

// File: tb/tb_arm_register_file.sv
// Scoreboard bench for arm_register_file: stimulus pushes expected reads,
// a negedge monitor pops and compares them.
module tb_arm_register_file;

  logic        clk;
  logic        reset;
  logic [3:0]  RA1, RA2, RA3, WA3, DbgSel;
  logic [31:0] WD3, LinkData, R15;
  logic        WE3, LinkWE;
  logic [31:0] RD1, RD2, RD3, DbgOut;

  arm_register_file dut (
    .clk(clk), .reset(reset),
    .RA1(RA1), .RA2(RA2), .RA3(RA3),
    .WA3(WA3), .WD3(WD3), .WE3(WE3),
    .LinkWE(LinkWE), .LinkData(LinkData),
    .R15(R15), .DbgSel(DbgSel),
    .RD1(RD1), .RD2(RD2), .RD3(RD3), .DbgOut(DbgOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port selectors for scoreboard entries
  localparam int P_RD1 = 0, P_RD2 = 1, P_RD3 = 2, P_DBG = 3, P_FLAG = 4;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Minimal ALU downstream: subtract InA-InB, zero flag registered when Flagwrite.
  logic flagwrite;
  logic alu_flag;
  always @(posedge clk) begin
    if (flagwrite) alu_flag <= ((RD1 - RD2) == 32'h0);
  end

  // Expected contents of R0-R14, set by hand at each write in the stimulus.
  logic [31:0] mdl [15];

  // Monitor: compare every pending expectation against the live outputs.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.port)
        P_RD1:   act = RD1;
        P_RD2:   act = RD2;
        P_RD3:   act = RD3;
        P_DBG:   act = DbgOut;
        default: act = {31'h0, alu_flag};
      endcase
      n_chk++;
      if (act === e.val) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", e.name, act, e.val);
    end
  end

  task automatic expect_port(input string name, input int port, input logic [31:0] val);
    exp_t e;
    e.name = name; e.port = port; e.val = val;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE3 = 1'b0; LinkWE = 1'b0; reset = 1'b0; flagwrite = 1'b0;
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < 15; i++) begin
      DbgSel = 4'(i);
      expect_port($sformatf("%s_r%0d", name, i), P_DBG, mdl[i]);
      cyc();
    end
  endtask

  initial begin
    for (int i = 0; i < 15; i++) mdl[i] = 32'h0;
    RA1 = 4'd0; RA2 = 4'd0; RA3 = 4'd0; DbgSel = 4'd0;
    R15 = 32'h0000_0008; LinkData = 32'h0; WD3 = 32'h0; WA3 = 4'd0;
    flagwrite = 1'b0; LinkWE = 1'b0;

    // Reset overrides a write presented in the same cycle
    reset = 1'b1; WE3 = 1'b1; WA3 = 4'd3; WD3 = 32'hDEADBEEF;
    cyc();
    idle(); RA1 = 4'd3;
    expect_port("rst_r3", P_RD1, 32'h0);
    sweep("rst");
    DbgSel = 4'd15;
    expect_port("dbg_r15", P_DBG, 32'h0000_0008);
    cyc();

    // Write commits at the edge; same-cycle read sees the old value
    WE3 = 1'b1; WA3 = 4'd5; WD3 = 32'h12345678; RA1 = 4'd5;
    expect_port("wr_old", P_RD1, 32'h0);
    cyc();
    mdl[5] = 32'h12345678;
    idle(); RA1 = 4'd5; RA2 = 4'd5; RA3 = 4'd5;
    expect_port("wr_rd1", P_RD1, 32'h12345678);
    expect_port("wr_rd2", P_RD2, 32'h12345678);
    expect_port("wr_rd3", P_RD3, 32'h12345678);
    cyc();

    // R15 comes from the input; writes to 15 are dropped
    R15 = 32'h0000_0108; RA2 = 4'd15;
    expect_port("r15_rd2", P_RD2, 32'h0000_0108);
    WE3 = 1'b1; WA3 = 4'd15; WD3 = 32'hFFFFFFFF;
    cyc();
    idle();
    expect_port("r15_after_wr", P_RD2, 32'h0000_0108);
    cyc();
    R15 = 32'h0000_010C;
    expect_port("r15_follow", P_RD2, 32'h0000_010C);
    cyc();
    sweep("r15wr");

    // Full-width data, no truncation
    WE3 = 1'b1; WA3 = 4'd0; WD3 = 32'h80000001;
    cyc();
    mdl[0] = 32'h80000001;
    idle(); RA1 = 4'd0;
    expect_port("width_r0", P_RD1, 32'h80000001);
    cyc();

    // Link conflict: general write to LR wins
    LinkWE = 1'b1; LinkData = 32'h40; WE3 = 1'b1; WA3 = 4'd14; WD3 = 32'h99;
    cyc();
    mdl[14] = 32'h99;
    idle(); RA1 = 4'd14;
    expect_port("link_conflict", P_RD1, 32'h99);
    cyc();
    // Link plus general write elsewhere: both commit
    LinkWE = 1'b1; LinkData = 32'h40; WE3 = 1'b1; WA3 = 4'd2; WD3 = 32'h99;
    cyc();
    mdl[14] = 32'h40; mdl[2] = 32'h99;
    idle(); RA1 = 4'd14; RA2 = 4'd2;
    expect_port("link_lr", P_RD1, 32'h40);
    expect_port("link_r2", P_RD2, 32'h99);
    cyc();

    // Reset mid-operation discards that cycle's writes
    WE3 = 1'b1; WA3 = 4'd7; WD3 = 32'hA5A5A5A5;
    cyc();
    idle(); RA3 = 4'd7;
    expect_port("pre_rst_r7", P_RD3, 32'hA5A5A5A5);
    cyc();
    reset = 1'b1; WE3 = 1'b1; WA3 = 4'd7; WD3 = 32'h1;
    LinkWE = 1'b1; LinkData = 32'h77;
    expect_port("rst_cycle_r7", P_RD3, 32'hA5A5A5A5);
    cyc();
    for (int i = 0; i < 15; i++) mdl[i] = 32'h0;
    idle(); RA1 = 4'd14;
    expect_port("mid_rst_r7", P_RD3, 32'h0);
    expect_port("mid_rst_lr", P_RD1, 32'h0);
    cyc();
    sweep("midrst");
    WE3 = 1'b1; WA3 = 4'd7; WD3 = 32'h1;
    cyc();
    idle();
    expect_port("post_rst_r7", P_RD3, 32'h1);
    cyc();

    // Operands feeding an ALU subtract: equal values set the zero flag
    WE3 = 1'b1; WA3 = 4'd1; WD3 = 32'hA;
    cyc();
    WA3 = 4'd2; WD3 = 32'hA;
    cyc();
    idle(); RA1 = 4'd1; RA2 = 4'd2; flagwrite = 1'b1;
    expect_port("alu_ina", P_RD1, 32'hA);
    expect_port("alu_inb", P_RD2, 32'hA);
    cyc();
    flagwrite = 1'b0;
    expect_port("alu_flag", P_FLAG, 32'h1);
    cyc();

    // Drain the scoreboard with a bounded wait
    for (int t = 0; t < 5 && q.size() > 0; t++) @(negedge clk);
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/arm_register_file.md
Name: arm_register_file

Overview:
- 16-entry register bank that feeds the ALU's InA/InB operands in the single-cycle ARM core.
- Holds R0–R14 in flops; R15 is the PC+8 value supplied by the fetch/PC logic and is not stored.
- Provides three combinational read ports: Rn, Rm/Rs, and Rd for the STR data path.
- Provides one general write port for the ALU/memory result and one dedicated link write for BL.

Parameters:
- DATA_W, 32, register and port data width.
- LINK_REG, 14, index written by the link port (BL return address).
- ADDR_W, 4, register address width; fixed at 4, not to be overridden.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- RA1  input  ADDR_W  read address, port 1 (drives ALU InA).
- RA2  input  ADDR_W  read address, port 2 (drives ALU InB path).
- RA3  input  ADDR_W  read address, port 3 (store data).
- WA3  input  ADDR_W  write address, general write port.
- WD3  input  DATA_W  write data, general write port.
- WE3  input  1  write enable, general write port.
- LinkWE  input  1  link write enable (BL).
- LinkData  input  DATA_W  return address to place in LINK_REG.
- R15  input  DATA_W  current PC+8 from PC stage.
- DbgSel  input  ADDR_W  debug readout select.
- RD1  output  DATA_W  read data, port 1.
- RD2  output  DATA_W  read data, port 2.
- RD3  output  DATA_W  read data, port 3.
- DbgOut  output  DATA_W  debug read data.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset). No asynchronous behaviour.
- Reset: at a rising edge with reset=1, R0–R14 become 0. Reset overrides WE3 and LinkWE in the same cycle. Reset asserted mid-program discards that cycle's pending writes.
- Outputs have no reset value of their own; they are combinational from state. After reset, reads of 0–14 return 0.
- Read ports (RD1, RD2, RD3, DbgOut):
  - Purely combinational, zero latency.
  - An address of 15 returns the R15 input; any other address returns the stored register.
- Write timing and bypass:
  - Writes commit at the rising edge and are visible on reads the following cycle.
  - A read of the address being written in the same cycle returns the old value; there is no write-to-read bypass.
- General write: at the rising edge with WE3=1 and reset=0, reg[WA3] <= WD3. A write with WA3=15 is silently ignored; PC updates belong to the PC stage.
- Link write: at the rising edge with LinkWE=1 and reset=0, reg[LINK_REG] <= LinkData.
- Simultaneous writes:
  - WE3=1 with WA3=LINK_REG and LinkWE=1 in the same cycle: WE3 data wins.
  - WE3 to any other register together with LinkWE: both writes commit.
- Width: the data path is a straight DATA_W copy, with no sign extension or truncation.
- State: one write-decode stage (reset / write / hold) per register. There is no multi-cycle FSM; sequential behaviour is the register bank itself.
- X-safety: an unknown address must not corrupt other registers. Write decode uses a full equality compare per register.

Decomposition:
- Shared package: ADDR_W, DATA_W, PC_IDX=15, LINK_REG=14, and the register index constants (SP=13, LR=14, PC=15). The package is shared with the decoder and the PC stage.
- One natural sub-module, regfile_read_mux: a 16:1 read mux with the R15 substitution. It is instantiated four times (RD1, RD2, RD3, DbgOut).

Test Plan:
- Reset with all writes active: assert reset for 1 cycle with WE3=1, WA3=3, WD3=32'hDEADBEEF → next cycle RD1 with RA1=3 reads 0; all R0–R14 read 0 via DbgSel sweep.
- Write/read-next-cycle: WE3=1, WA3=5, WD3=32'h12345678. In the same cycle RA1=5 reads the old value 0; the next cycle reads 32'h12345678. RD2 and RD3 with RA2=RA3=5 read the same value.
- R15 handling: R15=32'h00000108, RA2=15 → RD2=32'h00000108. Then WE3=1, WA3=15, WD3=32'hFFFFFFFF → RD2 still follows R15; DbgSel sweep shows R0–R14 unchanged.
- Link conflict: LinkWE=1, LinkData=32'h00000040, WE3=1, WA3=14, WD3=32'h00000099 → R14=32'h00000099. Repeat with WA3=2 → R14=32'h00000040 and R2=32'h00000099.
- Reset mid-operation: preload R7=32'hA5A5A5A5, then reset=1 together with WE3 to R7=32'h1 → R7 reads 0 after the edge. With reset=0 the next write to R7 succeeds.
- ALU integration: R1=32'h0000000A, R2=32'h0000000A, RA1=1, RA2=2 feeding ALU subtract with Flagwrite=1 → ALU Flag=1 after the next clock.
